layer2_mac_sequencer: RTL and testbench

- Controller for the layer-2 bank of 10 signed multiply-accumulate units (the neuron output stage).
- Loads biases and clears the accumulators, then accepts NUM_INPUTS layer-2 activations through a valid/ready stream.
- Fetches the matching weight row from synchronous weight RAM and pulses the bank's accumulate clock once per input.
- Captures the 10 sums and presents them downstream through a valid/ready handshake.

---
 rtl/layer2_mac_sequencer_if.sv | 39 +++
 rtl/layer2_mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_layer2_mac_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer2_mac_sequencer_if.sv
// Bus bundle for the layer-2 MAC sequencer: control strobes, activation stream,
// MAC bank/weight RAM controls and result stream. master = sequencer, slave = its surroundings.
interface layer2_mac_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int NUM_OUT = 10
);
  logic                     start;
  logic                     bias_load;
  logic                     busy;
  logic                     in_valid;
  logic [IN_W-1:0]          in_data;
  logic                     in_ready;
  logic [IN_W-1:0]          layer2_out;
  logic [ADDR_W-1:0]        weight_addr;
  logic                     bias_we;
  logic                     mac_clr;
  logic                     mac_step;
  logic [NUM_OUT*OUT_W-1:0] sum_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_OUT*OUT_W-1:0] result;
  logic [3:0]               class_idx;

  // Valid/ready: a beat moves on a rising clk edge where valid and ready are both
  // high; valid never waits on ready, and data is held while valid is high and ready is low.
  modport master (
    input  start, bias_load, in_valid, in_data, sum_in, out_ready,
    output busy, in_ready, layer2_out, weight_addr, bias_we, mac_clr, mac_step,
           out_valid, result, class_idx
  );

  modport slave (
    output start, bias_load, in_valid, in_data, sum_in, out_ready,
    input  busy, in_ready, layer2_out, weight_addr, bias_we, mac_clr, mac_step,
           out_valid, result, class_idx
  );
endinterface

// File: rtl/layer2_mac_sequencer.sv
// Sequencer for the layer-2 bank of signed MAC units: bias load, clear, per-input
// weight fetch and accumulate pulse, result capture. Optional argmax: LAYER2_ARGMAX_EN.
module layer2_mac_sequencer #(
  parameter int NUM_INPUTS = 32,
  parameter int ADDR_W     = 5,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16,
  parameter int NUM_OUT    = 10
) (
  input  logic                          clk,
  input  logic                          clr,
  layer2_mac_sequencer_if.master        bus,
  output logic [3:0]                    dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_BIAS    = 4'd1,
    S_CLEAR   = 4'd2,
    S_ACCEPT  = 4'd3,
    S_FETCH   = 4'd4,
    S_WAIT    = 4'd5,
    S_PULSE   = 4'd6,
    S_CAPTURE = 4'd7,
    S_SCAN    = 4'd8,
    S_OUTPUT  = 4'd9
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     busy_q;
  logic                     in_ready_q;
  logic [IN_W-1:0]          layer2_out_q;
  logic [ADDR_W-1:0]        weight_addr_q;
  logic                     bias_we_q;
  logic                     mac_clr_q;
  logic                     mac_step_q;
  logic                     out_valid_q;
  logic [NUM_OUT*OUT_W-1:0] result_q;

`ifdef LAYER2_ARGMAX_EN
  logic [3:0]               scan_q;
  logic [3:0]               best_idx_q;
  logic [3:0]               class_idx_q;
  logic signed [OUT_W-1:0]  best_q;
  logic signed [OUT_W-1:0]  word_cur;
  logic                     take_cur;
  logic [3:0]               win_idx;

  // Strictly-greater keeps the lowest index on ties; word 0 always seeds the search.
  always_comb begin
    word_cur = result_q[int'(scan_q)*OUT_W +: OUT_W];
    take_cur = (scan_q == 4'd0) || (word_cur > best_q);
    win_idx  = take_cur ? scan_q : best_idx_q;
  end

  assign bus.class_idx = class_idx_q;
`else
  assign bus.class_idx = 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.bias_load)  state_d = S_BIAS;
        else if (bus.start) state_d = S_CLEAR;
      end
      S_BIAS:   state_d = S_IDLE;
      S_CLEAR:  state_d = S_ACCEPT;
      S_ACCEPT: if (bus.in_valid) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   state_d = S_PULSE;
      S_PULSE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ACCEPT;
        end
      end
`ifdef LAYER2_ARGMAX_EN
      S_CAPTURE: state_d = S_SCAN;
      S_SCAN:    if (scan_q == 4'(NUM_OUT - 1)) state_d = S_OUTPUT;
`else
      S_CAPTURE: state_d = S_OUTPUT;
`endif
      S_OUTPUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each one is a clean register output
  // that is high for exactly the cycles spent in its state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      layer2_out_q  <= '0;
      weight_addr_q <= '0;
      bias_we_q     <= 1'b0;
      mac_clr_q     <= 1'b0;
      mac_step_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
`ifdef LAYER2_ARGMAX_EN
      scan_q        <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      best_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != S_IDLE);
      in_ready_q  <= (state_d == S_ACCEPT);
      bias_we_q   <= (state_d == S_BIAS);
      mac_clr_q   <= (state_d == S_CLEAR);
      mac_step_q  <= (state_d == S_PULSE);
      out_valid_q <= (state_d == S_OUTPUT);
      if (state_q == S_ACCEPT && bus.in_valid) begin
        layer2_out_q  <= bus.in_data;
        weight_addr_q <= cnt_q;
      end
      if (state_q == S_CAPTURE) begin
        result_q <= bus.sum_in;
      end
`ifdef LAYER2_ARGMAX_EN
      if (state_q == S_SCAN) begin
        scan_q <= scan_q + 1'b1;
        if (take_cur) begin
          best_q     <= word_cur;
          best_idx_q <= scan_q;
        end
        if (state_d == S_OUTPUT) class_idx_q <= win_idx;
      end else begin
        scan_q <= '0;
      end
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.layer2_out  = layer2_out_q;
  assign bus.weight_addr = weight_addr_q;
  assign bus.bias_we     = bias_we_q;
  assign bus.mac_clr     = mac_clr_q;
  assign bus.mac_step    = mac_step_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Bench for layer2_mac_sequencer: drives it with a behavioural MAC bank and weight RAM,
// and compares results against sums computed directly from biases, activations and weights.
module tb_layer2_mac_sequencer;

  localparam int NUM_INPUTS = 32;
  localparam int ADDR_W     = 5;
  localparam int IN_W       = 8;
  localparam int OUT_W      = 16;
  localparam int NUM_OUT    = 10;
  localparam int CW         = NUM_OUT * OUT_W;
`ifdef LAYER2_ARGMAX_EN
  localparam int SCAN_CYC   = NUM_OUT;
  localparam logic [3:0] TIE_IDX = 4'd2;
`else
  localparam int SCAN_CYC   = 0;
  localparam logic [3:0] TIE_IDX = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] dbg_state;

  layer2_mac_sequencer_if #(.ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W), .NUM_OUT(NUM_OUT)) bus ();

  layer2_mac_sequencer #(
    .NUM_INPUTS(NUM_INPUTS), .ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W), .NUM_OUT(NUM_OUT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment: weight RAM and MAC bank ----------------
  logic signed [IN_W-1:0] wram [NUM_INPUTS][NUM_OUT];
  logic signed [IN_W-1:0] wrow_q [NUM_OUT];
  logic [OUT_W-1:0]       bias_in [NUM_OUT];
  logic [OUT_W-1:0]       bank_bias [NUM_OUT];
  logic [OUT_W-1:0]       acc [NUM_OUT];
  logic                   step_d;

  always @(posedge clk) begin
    step_d <= bus.mac_step;
    for (int j = 0; j < NUM_OUT; j++) begin
      wrow_q[j] <= wram[bus.weight_addr][j];
      if (bus.bias_we) bank_bias[j] <= bias_in[j];
      if (bus.mac_clr)
        acc[j] <= bank_bias[j];
      else if (bus.mac_step && !step_d)
        acc[j] <= acc[j] + OUT_W'(int'($signed(bus.layer2_out)) * int'(wrow_q[j]));
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_sum
    assign bus.sum_in[j*OUT_W +: OUT_W] = acc[j];
  end

  // ---------------- scoreboard state ----------------
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  int               n_step, n_clr, n_bwe;
  logic             prev_step = 1'b0;
  logic [IN_W-1:0]  prev_l2 = '0;
  logic [IN_W-1:0]  exp_q[$];
  logic [IN_W-1:0]  acts [NUM_INPUTS];
  logic [OUT_W-1:0] cur_bias [NUM_OUT];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and audit every accumulate pulse seen there.
  task automatic tick();
    logic [IN_W-1:0] e;
    @(negedge clk);
    cyc++;
    if (bus.mac_step) begin
      chk("step_width", CW'(prev_step), CW'(0));
      chk("step_addr", CW'(bus.weight_addr), CW'(n_step));
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL step_extra observed=pulse %0d expected=no pulse", n_step);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("step_act", CW'(bus.layer2_out), CW'(e));
        chk("act_stable", CW'(prev_l2), CW'(bus.layer2_out));
      end
      n_step++;
    end
    if (bus.mac_clr) n_clr++;
    if (bus.bias_we) n_bwe++;
    prev_step = bus.mac_step;
    prev_l2   = bus.layer2_out;
  endtask

  // Reference: each sum is bias plus the dot product of activations and weight column.
  function automatic logic [CW-1:0] golden();
    logic [CW-1:0] g;
    int s;
    for (int j = 0; j < NUM_OUT; j++) begin
      s = int'($signed(cur_bias[j]));
      for (int k = 0; k < NUM_INPUTS; k++)
        s += int'($signed(acts[k])) * int'(wram[k][j]);
      g[j*OUT_W +: OUT_W] = OUT_W'(s);
    end
    return g;
  endfunction

  function automatic logic [3:0] exp_argmax(input logic [CW-1:0] g);
`ifdef LAYER2_ARGMAX_EN
    int best = 0;
    for (int j = 1; j < NUM_OUT; j++)
      if ($signed(g[j*OUT_W +: OUT_W]) > $signed(g[best*OUT_W +: OUT_W])) best = j;
    return 4'(best);
`else
    return (g == g) ? 4'd0 : 4'd0;
`endif
  endfunction

  task automatic chk_idle(input string pfx);
    chk({pfx, "_busy"},      CW'(bus.busy),        CW'(0));
    chk({pfx, "_in_ready"},  CW'(bus.in_ready),    CW'(0));
    chk({pfx, "_out_valid"}, CW'(bus.out_valid),   CW'(0));
    chk({pfx, "_bias_we"},   CW'(bus.bias_we),     CW'(0));
    chk({pfx, "_mac_clr"},   CW'(bus.mac_clr),     CW'(0));
    chk({pfx, "_mac_step"},  CW'(bus.mac_step),    CW'(0));
    chk({pfx, "_waddr"},     CW'(bus.weight_addr), CW'(0));
    chk({pfx, "_l2out"},     CW'(bus.layer2_out),  CW'(0));
    chk({pfx, "_result"},    bus.result,           CW'(0));
    chk({pfx, "_class"},     CW'(bus.class_idx),   CW'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_bias(input bit with_start);
    cur_bias = bias_in;
    n_bwe = 0;
    n_clr = 0;
    bus.bias_load = 1'b1;
    bus.start     = with_start;
    tick();
    bus.bias_load = 1'b0;
    bus.start     = 1'b0;
    repeat (3) tick();
    chk("bias_we_count", CW'(n_bwe), CW'(1));
    chk("bias_no_clear", CW'(n_clr), CW'(0));
    chk("bias_idle", CW'(bus.busy), CW'(0));
  endtask

  // One inference. stall_at: input index preceded by a 7-cycle in_valid drop (-1 none);
  // hold: cycles out_ready stays low with start and bias_load poked; abort_at: clr after that many inputs.
  task automatic run_inf(input int stall_at, input int hold, input bit zero_acts, input int abort_at);
    int t0, w;
    logic [CW-1:0] gold;
    logic [OUT_W-1:0] saved [NUM_OUT];
    for (int k = 0; k < NUM_INPUTS; k++) acts[k] = zero_acts ? '0 : IN_W'($urandom);
    exp_q.delete();
    n_step = 0; n_clr = 0; n_bwe = 0;
    saved = bias_in;
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    chk("clear_pulse", CW'(bus.mac_clr), CW'(1));
    if (hold > 0) begin
      bus.bias_load = 1'b1;
      for (int j = 0; j < NUM_OUT; j++) bias_in[j] = OUT_W'($urandom);
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (k == abort_at) begin
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 20) begin tick(); w++; end
        clr = 1'b1;
        #1;
        chk_idle("abort");
        tick();
        clr = 1'b0;
        tick();
        return;
      end
      if (k == stall_at) begin
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 20) begin tick(); w++; end
        repeat (7) begin
          tick();
          chk("stall_ready", CW'(bus.in_ready), CW'(1));
          chk("stall_no_step", CW'(bus.mac_step), CW'(0));
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = acts[k];
      w = 0;
      while (!bus.in_ready && w < 20) begin tick(); w++; end
      chk("accept_timeout", CW'(w < 20), CW'(1));
      exp_q.push_back(acts[k]);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.bias_load = 1'b0;
    bias_in = saved;
    w = 0;
    while (!bus.out_valid && w < 60) begin tick(); w++; end
    chk("out_valid_timeout", CW'(bus.out_valid), CW'(1));
    if (stall_at < 0) chk("latency", CW'(cyc - t0 - 1), CW'(4 * NUM_INPUTS + 2 + SCAN_CYC));
    gold = golden();
    chk("result", bus.result, gold);
    chk("class_idx", CW'(bus.class_idx), CW'(exp_argmax(gold)));
    chk("step_count", CW'(n_step), CW'(NUM_INPUTS));
    chk("clr_count", CW'(n_clr), CW'(1));
    chk("busy_bias_ignored", CW'(n_bwe), CW'(0));
    bus.start = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", CW'(bus.out_valid), CW'(1));
      chk("hold_result", bus.result, gold);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("done_valid", CW'(bus.out_valid), CW'(0));
    chk("done_idle", CW'(bus.busy), CW'(0));
    chk("done_no_restart", CW'(n_clr), CW'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clr           = 1'b1;
    bus.start     = 1'b0;
    bus.bias_load = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++)
      for (int j = 0; j < NUM_OUT; j++) wram[k][j] = IN_W'($urandom);
    for (int j = 0; j < NUM_OUT; j++) bias_in[j] = OUT_W'($urandom);
    repeat (2) tick();
    chk_idle("reset");
    clr = 1'b0;
    tick();

    load_bias(1'b1);
    run_inf(-1, 20, 1'b0, -1);
    run_inf(3, 0, 1'b0, -1);
    run_inf(-1, 0, 1'b0, 5);
    run_inf(-1, 0, 1'b0, -1);

    for (int j = 0; j < NUM_OUT; j++) bias_in[j] = '0;
    bias_in[0] = 16'hFFFB;
    bias_in[1] = 16'd3;
    bias_in[2] = 16'd9;
    bias_in[3] = 16'd9;
    load_bias(1'b0);
    run_inf(-1, 0, 1'b1, -1);
    chk("argmax_tie", CW'(bus.class_idx), CW'(TIE_IDX));

    for (int j = 0; j < NUM_OUT; j++) bias_in[j] = 16'h8000;
    load_bias(1'b0);
    run_inf(-1, 0, 1'b1, -1);
    chk("argmax_all_min", CW'(bus.class_idx), CW'(0));

    for (int j = 0; j < NUM_OUT; j++) bias_in[j] = OUT_W'($urandom_range(0, 65535));
    load_bias(1'b0);
    run_inf(-1, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
